jk_seq_driver: RTL and testbench

- Driver side of the JK flip-flop interface: produces per-bit J/K excitation so an external bank of WIDTH JK flip-flops steps through a programmed state sequence.
- Sequence types: binary up, binary down, Gray up, or a one-shot load to an arbitrary value.
- Reads the bank's Q outputs back, checks each landed state against the expected state, and flags any divergence.
- Sits between control logic and the counter/register datapaths built from JK cells.

---
 rtl/jk_pkg.sv | 36 +++
 rtl/jk_seq_driver_if.sv | 31 +++
 rtl/jk_excite.sv | 22 ++
 rtl/jk_seq_driver.sv | 131 +++++++++++++
 tb/tb_jk_seq_driver.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK sequence driver.
//   mode_e    : sequence type requested at start (up, down, Gray up, load)
//   state_e   : driver FSM state encoding
//   bin2gray / gray2bin : code conversions on a GW-bit word. Narrower values
//   are zero-extended before the call, so WIDTH may be anything up to GW.
package jk_pkg;

   localparam int GW = 32;

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_GRAY = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b[GW-1] = g[GW-1];
      for (int i = GW-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/jk_seq_driver_if.sv
// Control/bank-side bundle of the JK sequence driver.
//   master : control logic and JK bank (drives start/mode/len/load_val/q_fb)
//   slave  : jk_seq_driver (drives j/k excitation and status)
interface jk_seq_driver_if
   import jk_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int LEN_W = 8
) ();
   logic             start;
   mode_e            mode;
   logic [LEN_W-1:0] len;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q_fb;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             busy;
   logic             done;
   logic             mismatch;
   logic [LEN_W-1:0] step_cnt;

   modport master (
      output start, mode, len, load_val, q_fb,
      input  j, k, busy, done, mismatch, step_cnt
   );

   modport slave (
      input  start, mode, len, load_val, q_fb,
      output j, k, busy, done, mismatch, step_cnt
   );
endinterface

// File: rtl/jk_excite.sv
// Per-bit JK excitation: given present state q and desired next state n,
// produce j/k so a JK flip-flop lands on n at the next edge.
// Build option JK_TOGGLE_EN: changing bits get j=k=1 (toggle) instead of the
// default set/reset form (j=~q&n, k=q&~n). Both give the same landed state.
//   q, n : WIDTH-bit present/next state inputs
//   j, k : WIDTH-bit excitation outputs
module jk_excite #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k
);
`ifdef JK_TOGGLE_EN
   assign j = q ^ n;
   assign k = q ^ n;
`else
   assign j = ~q & n;
   assign k = q & ~n;
`endif
endmodule

// File: rtl/jk_seq_driver.sv
// Drives an external bank of WIDTH JK flip-flops through an up / down /
// Gray-up count or a one-shot load, reads the bank back and flags divergence.
// Build option JK_TOGGLE_EN selects toggle excitation (see jk_excite).
//   clk, rst_n : clock shared with the bank, async active-low reset
//   bus        : jk_seq_driver_if.slave (start/mode/len/load_val/q_fb in,
//                j/k/busy/done/mismatch/step_cnt out)
//
// state   | meaning
// IDLE    | bank held (j=k=0), waiting for start
// RUN     | one bank edge driven per cycle toward the next sequence value
// DONE    | bank held, last landed state checked, done pulsed
module jk_seq_driver
   import jk_pkg::*;
#(
   parameter int WIDTH = 4,   // 2..GW
   parameter int LEN_W = 8
) (
   input logic             clk,
   input logic             rst_n,
   jk_seq_driver_if.slave  bus
);
   state_e           state_q;
   mode_e            mode_q;
   logic [LEN_W-1:0] len_q;
   logic [WIDTH-1:0] load_val_q;
   logic [WIDTH-1:0] exp_q;
   logic             chk_q;
   logic             busy_q;
   logic             done_q;
   logic             mismatch_q;
   logic [LEN_W-1:0] step_cnt_q;
   logic [LEN_W-1:0] step_cnt_d;

   logic [WIDTH-1:0] gray_bin;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] n_drive;
   logic [WIDTH-1:0] j_w;
   logic [WIDTH-1:0] k_w;

   // Truncate to WIDTH before re-encoding so the Gray count wraps cleanly.
   assign gray_bin   = WIDTH'(gray2bin(GW'(bus.q_fb))) + WIDTH'(1);
   assign step_cnt_d = step_cnt_q + LEN_W'(1);

   always_comb begin
      nxt = bus.q_fb;
      case (mode_q)
         MODE_UP:   nxt = bus.q_fb + WIDTH'(1);
         MODE_DOWN: nxt = bus.q_fb - WIDTH'(1);
         MODE_GRAY: nxt = WIDTH'(bin2gray(GW'(gray_bin)));
         MODE_LOAD: nxt = load_val_q;
         default:   nxt = bus.q_fb;
      endcase
   end

   // Asking for "next = present" outside RUN yields j=k=0 in either encoding.
   assign n_drive = (state_q == ST_RUN) ? nxt : bus.q_fb;

   jk_excite #(.WIDTH(WIDTH)) u_excite (
      .q (bus.q_fb),
      .n (n_drive),
      .j (j_w),
      .k (k_w)
   );

   assign bus.j        = j_w;
   assign bus.k        = k_w;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.mismatch = mismatch_q;
   assign bus.step_cnt = step_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_UP;
         len_q      <= '0;
         load_val_q <= '0;
         exp_q      <= '0;
         chk_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mismatch_q <= 1'b0;
         step_cnt_q <= '0;
      end else begin
         // Check the state landed by the previous edge; start clears below.
         if (chk_q && (bus.q_fb != exp_q)) mismatch_q <= 1'b1;

         case (state_q)
            ST_IDLE: begin
               chk_q  <= 1'b0;
               done_q <= 1'b0;
               if (bus.start) begin
                  mode_q     <= bus.mode;
                  len_q      <= bus.len;
                  load_val_q <= bus.load_val;
                  step_cnt_q <= '0;
                  mismatch_q <= 1'b0;
                  if ((bus.mode == MODE_LOAD) || (bus.len != '0)) begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               exp_q      <= nxt;
               chk_q      <= 1'b1;
               step_cnt_q <= step_cnt_d;
               if ((mode_q == MODE_LOAD) || (step_cnt_d == len_q)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               chk_q   <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               chk_q   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: a 4-cell JK bank model (preloadable by forcing its
// j/k), directed sequences with hand-computed results, and a scoreboard
// monitor that checks first-cycle j/k on busy rise and the landed state,
// step count and mismatch flag on each done pulse.
module tb_jk_seq_driver;
   import jk_pkg::*;

   localparam int W = 4;
   localparam int L = 8;
`ifdef JK_TOGGLE_EN
   localparam bit TOG = 1'b1;
`else
   localparam bit TOG = 1'b0;
`endif

   typedef struct {
      logic         has_jk;
      logic [W-1:0] j;
      logic [W-1:0] k;
      logic [W-1:0] q;
      logic [L-1:0] step;
      logic         mm;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jk_seq_driver_if #(.WIDTH(W), .LEN_W(L)) bus ();

   jk_seq_driver #(.WIDTH(W), .LEN_W(L)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // JK bank model
   logic [W-1:0] q_bank = '0;
   logic [W-1:0] stuck0 = '0;
   logic         frc_en = 1'b0;
   logic [W-1:0] frc_val = '0;
   logic [W-1:0] bj, bk;
   assign bj = frc_en ? frc_val : bus.j;
   assign bk = frc_en ? ~frc_val : bus.k;
   assign bus.q_fb = q_bank & ~stuck0;

   always @(posedge clk) begin
      for (int i = 0; i < W; i++) begin
         case ({bj[i], bk[i]})
            2'b01:   q_bank[i] <= 1'b0;
            2'b10:   q_bank[i] <= 1'b1;
            2'b11:   q_bank[i] <= ~q_bank[i];
            default: q_bank[i] <= q_bank[i];
         endcase
      end
   end

   int total = 0;
   int bad = 0;
   exp_t sb[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   // Scoreboard monitor
   exp_t cur;
   logic have = 1'b0;
   logic busy_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         have = 1'b0;
         busy_prev = 1'b0;
      end else begin
         if (bus.busy && !busy_prev && sb.size() > 0) begin
            cur = sb.pop_front();
            have = 1'b1;
            if (cur.has_jk) begin
               check("first_j", 32'(bus.j), 32'(cur.j));
               check("first_k", 32'(bus.k), 32'(cur.k));
            end
         end
         if (bus.done) begin
            if (!have && sb.size() > 0) begin
               cur = sb.pop_front();
               have = 1'b1;
            end
            if (have) begin
               check("done_q", 32'(bus.q_fb), 32'(cur.q));
               check("done_step", 32'(bus.step_cnt), 32'(cur.step));
               check("done_mismatch", 32'(bus.mismatch), 32'(cur.mm));
               have = 1'b0;
            end else begin
               check("unexpected_done", 32'(bus.done), 32'd0);
            end
         end
         busy_prev = bus.busy;
      end
   end

   task automatic preload(input logic [W-1:0] v);
      @(posedge clk); #1;
      frc_en = 1'b1; frc_val = v;
      @(posedge clk); #1;
      frc_en = 1'b0;
   endtask

   task automatic run_seq(input mode_e m, input logic [L-1:0] ln, input logic [W-1:0] lv,
                          input logic [W-1:0] pre, input logic has_jk,
                          input logic [W-1:0] jd, input logic [W-1:0] kd,
                          input logic [W-1:0] jt, input logic [W-1:0] kt,
                          input logic [W-1:0] qf, input logic [L-1:0] st,
                          input logic mm, input logic poke);
      exp_t e;
      logic got;
      preload(pre);
      e.has_jk = has_jk;
      e.j = TOG ? jt : jd;
      e.k = TOG ? kt : kd;
      e.q = qf; e.step = st; e.mm = mm;
      sb.push_back(e);
      bus.start = 1'b1; bus.mode = m; bus.len = ln; bus.load_val = lv;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (poke) begin
         // A start while busy must be ignored.
         @(posedge clk); #1;
         bus.start = 1'b1; bus.mode = MODE_LOAD; bus.load_val = 4'hF; bus.len = 8'd1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (bus.done) got = 1'b1;
      end
      check("done_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      bus.start = 1'b0; bus.mode = MODE_UP; bus.len = '0; bus.load_val = '0;
      #2;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_mismatch", 32'(bus.mismatch), 32'd0);
      check("rst_step", 32'(bus.step_cnt), 32'd0);
      check("rst_j", 32'(bus.j), 32'd0);
      check("rst_k", 32'(bus.k), 32'd0);
      #20 rst_n = 1'b1;

      //      mode       len   lv     pre    jk  jd     kd     jt     kt     q      st  mm poke
      run_seq(MODE_UP,   8'd3, 4'h0, 4'h0, 1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h3, 8'd3, 0, 0);
      run_seq(MODE_DOWN, 8'd1, 4'h0, 4'h0, 1, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 8'd1, 0, 0);
      run_seq(MODE_GRAY, 8'd1, 4'h0, 4'h3, 1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h2, 8'd1, 0, 0);
      run_seq(MODE_LOAD, 8'd5, 4'hA, 4'h6, 1, 4'h8, 4'h4, 4'hC, 4'hC, 4'hA, 8'd1, 0, 0);
      run_seq(MODE_UP,   8'd1, 4'h0, 4'hF, 1, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 8'd1, 0, 0);
      run_seq(MODE_GRAY, 8'd4, 4'h0, 4'h0, 1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h6, 8'd4, 0, 1);

      // Feedback bit 1 stuck low: divergence after the second edge.
      stuck0 = 4'b0010;
      run_seq(MODE_UP,   8'd4, 4'h0, 4'h0, 1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 8'd4, 1, 0);
      stuck0 = 4'b0000;
      repeat (2) @(posedge clk);
      #1 check("mismatch_sticky", 32'(bus.mismatch), 32'd1);
      check("step_hold", 32'(bus.step_cnt), 32'd4);

      // len=0: straight to done, nothing driven, mismatch cleared by start.
      run_seq(MODE_UP,   8'd0, 4'h0, 4'h5, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 8'd0, 0, 0);

      // Reset mid-run after two edges.
      preload(4'h0);
      bus.start = 1'b1; bus.mode = MODE_UP; bus.len = 8'd8;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_j", 32'(bus.j), 32'd0);
      check("abort_k", 32'(bus.k), 32'd0);
      check("abort_step", 32'(bus.step_cnt), 32'd0);
      check("abort_q", 32'(bus.q_fb), 32'h2);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1 check("abort_q_held", 32'(bus.q_fb), 32'h2);
      check("abort_sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
